// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the 64-bit five-stage core: widths, ALU op codes,
// the decoded control bundle and the write-back bypass select.
package riscv_pipe_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_LUI  = 4'hA
    } alu_op_e;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
        logic                branch;
    } ctrl_t;

    // Register-file read data, replaced by the write-back value when WB is
    // writing the same non-zero register in the capture cycle.
    function automatic logic [XLEN-1:0] wb_bypass(
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_data,
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rf_data
    );
        if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            return wb_data;
        end
        return rf_data;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Raw load-use hazard term: a load in EX whose destination is read by the
// valid instruction sitting in ID.
module load_use_detect
    import riscv_pipe_pkg::*;
(
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              id_valid_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    output logic              load_use_c_o
);

    logic rs1_hit_c;
    logic rs2_hit_c;

    assign rs1_hit_c = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit_c = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 is hardwired to zero, so a load to x0 never creates a dependency.
    assign load_use_c_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0)
                       && id_valid_i && (rs1_hit_c || rs2_hit_c);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush and WB bypass.
// Optional perf counters are enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage_reg
    import riscv_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  ctrl_t             id_ctrl,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output ctrl_t             ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    logic              valid_q,    valid_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q,      imm_d;
    logic [REG_AW-1:0] rs1_q,      rs1_d;
    logic [REG_AW-1:0] rs2_q,      rs2_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    ctrl_t             ctrl_q,     ctrl_d;

    logic load_use_c;
    logic bubble_c;

    load_use_detect u_load_use_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_i       (rd_q),
        .id_valid_i    (id_valid),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .load_use_c_o  (load_use_c)
    );

    // A flushed instruction is dead, so it must not stall the front end.
    assign hazard_stall = load_use_c && !flush;
    assign bubble_c     = flush || hazard_stall;

    // Next-state: stall holds everything, bubbles kill only valid/ctrl/rd.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        if (!mem_stall) begin
            if (bubble_c) begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                rd_d    = '0;
            end else begin
                valid_d    = id_valid;
                pc_d       = id_pc;
                rs1_data_d = wb_bypass(wb_reg_write, wb_rd, wb_data, id_rs1, id_rs1_data);
                rs2_data_d = wb_bypass(wb_reg_write, wb_rd, wb_data, id_rs2, id_rs2_data);
                imm_d      = id_imm;
                rs1_d      = id_rs1;
                rs2_d      = id_rs2;
                rd_d       = id_rd;
                ctrl_d     = id_valid ? id_ctrl : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_ctrl     = ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q,  flush_cnt_d;

    // Saturating event counters; a frozen stage records nothing.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!mem_stall && hazard_stall && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (!mem_stall && flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus a random
// run, all checked against a scoreboard fed by a behavioural model.
module tb_id_ex_stage_reg;
    import riscv_pipe_pkg::*;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1d;
        logic [XLEN-1:0]   rs2d;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        ctrl_t             ctrl;
    } ex_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_uses_rs1, id_uses_rs2;
    ctrl_t             id_ctrl;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush, mem_stall;
    logic              hazard_stall, ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    ctrl_t             ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]       perf_bubble_cnt, perf_flush_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    ex_t  m;
    ex_t  sb[$];
    logic [31:0] m_bub, m_fl;

    id_ex_stage_reg dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_ctrl      (id_ctrl),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .hazard_stall (hazard_stall),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_ctrl      (ex_ctrl)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic ctrl_t mk_ctrl(input logic [3:0] op, input logic src,
                                      input logic mr, input logic mw, input logic rw);
        ctrl_t c;
        c.alu_op     = op;
        c.alu_src    = src;
        c.mem_read   = mr;
        c.mem_write  = mw;
        c.reg_write  = rw;
        c.mem_to_reg = mr;
        c.branch     = 1'b0;
        return c;
    endfunction

    task automatic idle();
        id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_ctrl = '0; wb_reg_write = 0; wb_rd = '0; wb_data = '0;
        flush = 0; mem_stall = 0;
    endtask

    task automatic set_id(input logic [XLEN-1:0] pc, input logic [REG_AW-1:0] rs1,
                          input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd,
                          input logic u1, input logic u2, input ctrl_t c);
        id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = c;
        id_rs1_data = {32'hA000_0000, 27'd0, rs1};
        id_rs2_data = {32'hB000_0000, 27'd0, rs2};
        id_imm      = pc + 64'h40;
    endtask

    // One clock: check hazard_stall, push model next state, compare after edge.
    task automatic cycle(input string name);
        ex_t  nxt, got, exp;
        logic hz;
        #1;
        hz = m.valid && m.ctrl.mem_read && (m.rd != '0) && id_valid
             && ((id_uses_rs1 && (id_rs1 == m.rd)) || (id_uses_rs2 && (id_rs2 == m.rd)))
             && !flush;
        checks++;
        if (hazard_stall !== hz) begin
            errors++;
            $display("FAIL %s hazard_stall got %b expected %b", name, hazard_stall, hz);
        end
        nxt = m;
        if (!mem_stall) begin
            if (flush || hz) begin
                nxt.valid = 1'b0;
                nxt.ctrl  = '0;
                nxt.rd    = '0;
                if (flush) m_fl = sat_inc(m_fl);
                else       m_bub = sat_inc(m_bub);
            end else begin
                nxt.valid = id_valid;
                nxt.pc    = id_pc;
                nxt.rs1d  = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
                nxt.rs2d  = (wb_reg_write && wb_rd != '0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;
                nxt.imm   = id_imm;
                nxt.rs1   = id_rs1;
                nxt.rs2   = id_rs2;
                nxt.rd    = id_rd;
                nxt.ctrl  = id_valid ? id_ctrl : '0;
            end
        end
        sb.push_back(nxt);
        m = nxt;
        @(posedge clk);
        #1;
        got.valid = ex_valid; got.pc = ex_pc; got.rs1d = ex_rs1_data; got.rs2d = ex_rs2_data;
        got.imm = ex_imm; got.rs1 = ex_rs1; got.rs2 = ex_rs2; got.rd = ex_rd; got.ctrl = ex_ctrl;
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s ex_regs got %h expected %h", name, got, exp);
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (perf_bubble_cnt !== m_bub || perf_flush_cnt !== m_fl) begin
            errors++;
            $display("FAIL %s perf got %0d/%0d expected %0d/%0d", name,
                     perf_bubble_cnt, perf_flush_cnt, m_bub, m_fl);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            id_valid = 1; id_pc = {$urandom, $urandom}; id_rs1_data = {$urandom, $urandom};
            id_rs2_data = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
            id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
            id_uses_rs1 = 1; id_uses_rs2 = 1; id_ctrl = 10'($urandom) | 10'h0FF;
            @(posedge clk);
            #1;
        end
        checks++;
        if ({ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl, hazard_stall} !== '0) begin
            errors++;
            $display("FAIL reset outputs got valid=%b pc=%h rd=%0d ctrl=%h hz=%b expected all 0",
                     ex_valid, ex_pc, ex_rd, ex_ctrl, hazard_stall);
        end
        m = '0; m_bub = '0; m_fl = '0;
        idle();
        rst_n = 1;
    endtask

    task automatic test_capture();
        set_id(64'h1000, 5'd1, 5'd2, 5'd10, 1, 1, mk_ctrl(4'h2, 0, 0, 0, 1));
        id_rs1_data = 64'h5;
        cycle("capture");
        checks++;
        if (ex_pc !== 64'h1000 || ex_rs1_data !== 64'h5 || ex_valid !== 1'b1 || ex_ctrl.alu_op !== 4'h2) begin
            errors++;
            $display("FAIL capture_direct got pc=%h rs1d=%h v=%b op=%h expected 1000/5/1/2",
                     ex_pc, ex_rs1_data, ex_valid, ex_ctrl.alu_op);
        end
    endtask

    task automatic test_load_use();
        set_id(64'h2000, 5'd1, 5'd0, 5'd5, 1, 0, mk_ctrl(ALU_ADD, 1, 1, 0, 1));
        cycle("lu_load");
        set_id(64'h2004, 5'd5, 5'd7, 5'd6, 1, 1, mk_ctrl(ALU_ADD, 0, 0, 0, 1));
        #1;
        checks++;
        if (hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_hazard got %b expected 1", hazard_stall);
        end
        cycle("lu_bubble");
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0) begin
            errors++;
            $display("FAIL lu_bubble_direct got v=%b ctrl=%h rd=%0d expected 0/0/0", ex_valid, ex_ctrl, ex_rd);
        end
        cycle("lu_consumer");
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 64'h2004) begin
            errors++;
            $display("FAIL lu_consumer_direct got v=%b rd=%0d pc=%h expected 1/6/2004", ex_valid, ex_rd, ex_pc);
        end
    endtask

    task automatic test_x0();
        set_id(64'h3000, 5'd2, 5'd0, 5'd0, 1, 0, mk_ctrl(ALU_ADD, 1, 1, 0, 1));
        cycle("x0_load");
        set_id(64'h3004, 5'd0, 5'd0, 5'd8, 1, 1, mk_ctrl(ALU_OR, 0, 0, 0, 1));
        cycle("x0_consumer");
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 64'h3004) begin
            errors++;
            $display("FAIL x0_no_bubble got v=%b pc=%h expected 1/3004", ex_valid, ex_pc);
        end
    endtask

    task automatic test_wb_bypass();
        set_id(64'h4000, 5'd4, 5'd3, 5'd9, 1, 1, mk_ctrl(ALU_SUB, 0, 0, 0, 1));
        id_rs2_data = '0;
        wb_reg_write = 1; wb_rd = 5'd3; wb_data = 64'hDEAD;
        cycle("wb_bypass");
        checks++;
        if (ex_rs2_data !== 64'hDEAD || ex_rs1_data !== {32'hA000_0000, 32'd4}) begin
            errors++;
            $display("FAIL wb_bypass_direct got rs2d=%h rs1d=%h expected dead/a000000000000004",
                     ex_rs2_data, ex_rs1_data);
        end
        set_id(64'h4004, 5'd0, 5'd0, 5'd9, 1, 1, mk_ctrl(ALU_ADD, 0, 0, 0, 1));
        wb_reg_write = 1; wb_rd = 5'd0; wb_data = 64'hBEEF;
        cycle("wb_x0");
        checks++;
        if (ex_rs1_data !== {32'hA000_0000, 32'd0}) begin
            errors++;
            $display("FAIL wb_x0_direct got %h expected a000000000000000", ex_rs1_data);
        end
        idle();
    endtask

    task automatic test_priority();
        logic [31:0] bub0, fl0;
        set_id(64'h5000, 5'd1, 5'd0, 5'd5, 1, 0, mk_ctrl(ALU_ADD, 1, 1, 0, 1));
        cycle("prio_load");
        set_id(64'h5004, 5'd5, 5'd5, 5'd6, 1, 1, mk_ctrl(ALU_AND, 0, 0, 0, 1));
        flush = 1; mem_stall = 1;
        bub0 = m_bub; fl0 = m_fl;
        cycle("prio_stall");
        cycle("prio_stall2");
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_pc !== 64'h5000) begin
            errors++;
            $display("FAIL prio_hold got v=%b rd=%0d pc=%h expected 1/5/5000", ex_valid, ex_rd, ex_pc);
        end
        mem_stall = 0;
        cycle("prio_flush");
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_pc !== 64'h5000) begin
            errors++;
            $display("FAIL prio_flush_direct got v=%b ctrl=%h pc=%h expected 0/0/5000", ex_valid, ex_ctrl, ex_pc);
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (perf_flush_cnt !== fl0 + 32'd1 || perf_bubble_cnt !== bub0) begin
            errors++;
            $display("FAIL prio_perf got fl=%0d bub=%0d expected %0d/%0d",
                     perf_flush_cnt, perf_bubble_cnt, fl0 + 32'd1, bub0);
        end
`endif
        flush = 0;
        cycle("prio_resume");
    endtask

    task automatic test_back_to_back();
        set_id(64'h6000, 5'd1, 5'd0, 5'd5, 1, 0, mk_ctrl(ALU_ADD, 1, 1, 0, 1));
        cycle("b2b_ld1");
        set_id(64'h6004, 5'd5, 5'd0, 5'd6, 1, 0, mk_ctrl(ALU_ADD, 1, 1, 0, 1));
        cycle("b2b_bubble1");
        cycle("b2b_ld2");
        set_id(64'h6008, 5'd2, 5'd6, 5'd7, 1, 1, mk_ctrl(ALU_XOR, 0, 0, 0, 1));
        cycle("b2b_bubble2");
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble2_direct got v=%b expected 0", ex_valid);
        end
        cycle("b2b_use");
        idle();
        cycle("b2b_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            id_valid    = ($urandom_range(0, 9) != 0);
            id_pc       = {$urandom, $urandom};
            id_rs1_data = {$urandom, $urandom};
            id_rs2_data = {$urandom, $urandom};
            id_imm      = {$urandom, $urandom};
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_rd       = 5'($urandom_range(0, 7));
            id_uses_rs1 = 1'($urandom);
            id_uses_rs2 = 1'($urandom);
            id_ctrl     = 10'($urandom);
            if ($urandom_range(0, 2) == 0) id_ctrl.mem_read = 1'b1;
            wb_reg_write = 1'($urandom);
            wb_rd        = 5'($urandom_range(0, 7));
            wb_data      = {$urandom, $urandom};
            flush        = ($urandom_range(0, 9) == 0);
            mem_stall    = ($urandom_range(0, 9) == 0);
            cycle("random");
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        set_id(64'h7000, 5'd1, 5'd0, 5'd5, 1, 0, mk_ctrl(ALU_ADD, 1, 1, 0, 1));
        cycle("rst_mid_load");
        rst_n = 0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_pc !== '0 || ex_rd !== '0 || ex_ctrl !== '0) begin
            errors++;
            $display("FAIL rst_async got v=%b pc=%h rd=%0d ctrl=%h expected 0", ex_valid, ex_pc, ex_rd, ex_ctrl);
        end
        m = '0; m_bub = '0; m_fl = '0;
        @(posedge clk);
        #1;
        rst_n = 1;
        set_id(64'h7100, 5'd5, 5'd0, 5'd6, 1, 0, mk_ctrl(ALU_ADD, 0, 0, 0, 1));
        cycle("rst_first_capture");
    endtask

    initial begin
        idle();
        m = '0; m_bub = '0; m_fl = '0;
        test_reset();
        test_capture();
        test_load_use();
        test_x0();
        test_wb_bypass();
        test_priority();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the 64-bit five-stage core. It captures decoded operands and control from the decode stage and presents them to the EX stage, where the ALU operand forwarding muxes consume them. It also owns load-use hazard detection, bubble insertion, branch flush and the write-back bypass into the captured operands. The forwarding muxes cannot resolve a load result in time, so this block handles that case.

## Interface
- XLEN, 64: datapath width.
- REG_AW, 5: register index width.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REG_AW  register indices.
- id_uses_rs1, id_uses_rs2  in  1  operand is actually read.
- id_ctrl  in  ctrl_t  alu_op[3:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch.
- wb_reg_write  in  1  MEM/WB writing the register file this cycle.
- wb_rd  in  REG_AW  write-back destination.
- wb_data  in  XLEN  write-back value.
- flush  in  1  taken branch or redirect; kill the instruction entering EX.
- mem_stall  in  1  back-end stall; freeze this register.
- hazard_stall  out  1  hold PC and IF/ID (load-use).
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered indices, used by the forwarding unit.
- ex_ctrl  out  ctrl_t  registered control; all-zero when ex_valid=0.

## Operation
- Load-use hazard: hazard_stall = ex_valid & ex_ctrl.mem_read & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). Combinational from EX registers and ID inputs. Forced to 0 while flush=1.
- WB bypass on capture: if wb_reg_write & wb_rd!=0 & wb_rd==id_rs1, then wb_data is captured as rs1 data. rs2 is handled the same way. x0 is never bypassed.
- Per-edge update, in priority order:
  1. mem_stall=1: all registers hold. flush and the hazard are ignored, and upstream keeps flush asserted until the stall clears. hazard_stall is still computed.
  2. flush=1: insert a bubble. ex_valid=0, ex_ctrl=0, ex_rd=0, and data fields hold their previous values.
  3. hazard_stall=1: insert a bubble as in step 2. The ID instruction is re-presented on the next cycle.
  4. Otherwise: capture all ID fields. ex_valid=id_valid. ex_ctrl=id_valid ? id_ctrl : 0.
- A bubble never asserts reg_write, mem_read or mem_write downstream.

## Timing
- Reset (async, rst_n=0): ex_valid=0, ex_ctrl=0, all index and data outputs 0. hazard_stall=0 follows from ex_valid=0.
- Latency: one cycle from ID inputs to ex_* outputs.
- A load-use stall lasts exactly one cycle. After the bubble, ex_mem_read=0, so hazard_stall drops and the consumer is captured on the next edge. The load result then reaches the consumer through the MEM/WB forwarding path.
- Back-to-back load then dependent load: each dependent instruction gets one bubble.
- Reset released mid-stream: the first capture occurs on the first rising edge with rst_n=1.

## Configuration
- ID_EX_PERF_CNT_EN defined: adds outputs perf_bubble_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_bubble_cnt increments on each load-use bubble edge.
  - perf_flush_cnt increments on each flush edge.
  - Neither counter increments under mem_stall.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- ID_EX_PERF_CNT_EN undefined: the ports and logic are absent, and the rest of the behaviour is identical.

## Structure
- Shared package riscv_pipe_pkg holds XLEN, REG_AW, the ctrl_t packed struct and the alu_op encodings. The EX, MEM and WB stages reuse the same package.
- One sub-module, load_use_detect: combinational, produces the raw hazard term. Instantiated once.

## Test plan
- Reset: hold rst_n=0 with random inputs, then release. Required: all outputs 0 and hazard_stall=0.
- Plain capture: id_valid=1, id_pc=64'h1000, id_rs1_data=64'h5, alu_op=4'h2, no hazard. Required: the next cycle shows ex_pc=64'h1000, ex_rs1_data=5, ex_valid=1.
- Load-use: ld x5 in EX, then ID add x6,x5,x7. Required: hazard_stall=1 for one cycle, then a bubble (ex_valid=0, ex_ctrl=0), then the add captured.
- x0 destination: load to x0 with a consumer of x0. Required: hazard_stall=0 and no bubble.
- WB bypass: wb_reg_write=1, wb_rd=3, wb_data=64'hDEAD, id_rs2=3, id_rs2_data=0. Required: ex_rs2_data=64'hDEAD.
- Priority: mem_stall=1 together with flush=1 and a load-use hazard. Required: all registers hold. Release mem_stall with flush still high. Required: bubble, with the perf counters (if enabled) showing flush +1 and bubble +0.
